// File: rtl/axim_wr_controller_pkg.sv
// Shared AXI master definitions for the read and write controllers:
// controller state encoding, number of HP ports and the burst byte count.
package axim_wr_controller_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } axim_state_t;

  // Bytes moved by one burst of burst_len beats on a data_width-bit bus.
  function automatic int unsigned burst_bytes(input int unsigned data_width,
                                              input int unsigned burst_len);
    return (data_width / 8) * burst_len;
  endfunction

endpackage

// File: rtl/axim_wr_controller_if.sv
// Request/port bundle of the write controller.
//   tx_req/tx_size/tx_addr  -> request from the client
//   tx_ready/tx_done        <- controller status
//   axim_hpN_tx_req/size/addr  <- sub-request to HP write port N
//   axim_hpN_tx_done           -> port N finished its sub-request
// master: the controller side; slave: client plus HP ports.
interface axim_wr_controller_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned TX_SIZE_WIDTH      = 10
);
  logic                          tx_req;
  logic [TX_SIZE_WIDTH-1:0]      tx_size;
  logic [C_M_AXI_ADDR_WIDTH-1:0] tx_addr;
  logic                          tx_ready;
  logic                          tx_done;

  logic                          axim_hp0_tx_req;
  logic [TX_SIZE_WIDTH-1:0]      axim_hp0_tx_size;
  logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp0_tx_addr;
  logic                          axim_hp0_tx_done;
  logic                          axim_hp1_tx_req;
  logic [TX_SIZE_WIDTH-1:0]      axim_hp1_tx_size;
  logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp1_tx_addr;
  logic                          axim_hp1_tx_done;
  logic                          axim_hp2_tx_req;
  logic [TX_SIZE_WIDTH-1:0]      axim_hp2_tx_size;
  logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp2_tx_addr;
  logic                          axim_hp2_tx_done;
  logic                          axim_hp3_tx_req;
  logic [TX_SIZE_WIDTH-1:0]      axim_hp3_tx_size;
  logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp3_tx_addr;
  logic                          axim_hp3_tx_done;

  modport master (
    input  tx_req, tx_size, tx_addr,
    output tx_ready, tx_done,
    output axim_hp0_tx_req, axim_hp0_tx_size, axim_hp0_tx_addr,
    output axim_hp1_tx_req, axim_hp1_tx_size, axim_hp1_tx_addr,
    output axim_hp2_tx_req, axim_hp2_tx_size, axim_hp2_tx_addr,
    output axim_hp3_tx_req, axim_hp3_tx_size, axim_hp3_tx_addr,
    input  axim_hp0_tx_done, axim_hp1_tx_done, axim_hp2_tx_done, axim_hp3_tx_done
  );

  modport slave (
    output tx_req, tx_size, tx_addr,
    input  tx_ready, tx_done,
    input  axim_hp0_tx_req, axim_hp0_tx_size, axim_hp0_tx_addr,
    input  axim_hp1_tx_req, axim_hp1_tx_size, axim_hp1_tx_addr,
    input  axim_hp2_tx_req, axim_hp2_tx_size, axim_hp2_tx_addr,
    input  axim_hp3_tx_req, axim_hp3_tx_size, axim_hp3_tx_addr,
    output axim_hp0_tx_done, axim_hp1_tx_done, axim_hp2_tx_done, axim_hp3_tx_done
  );
endinterface

// File: rtl/axim_wr_split.sv
// Combinational split of a burst count over the HP ports.
//   tx_size/tx_addr  : total bursts and start byte address
//   port_size[N]     : size/4 plus one for the first size%4 ports
//   port_addr[N]     : start address of port N (wraps modulo 2^ADDR_W)
//   port_mask[N]     : port N receives a non-empty share
module axim_wr_split
  import axim_wr_controller_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SIZE_W      = 10,
  parameter int unsigned BURST_BYTES = 128
) (
  input  logic [SIZE_W-1:0]                 tx_size,
  input  logic [ADDR_W-1:0]                 tx_addr,
  output logic [NUM_PORTS-1:0][SIZE_W-1:0]  port_size,
  output logic [NUM_PORTS-1:0][ADDR_W-1:0]  port_addr,
  output logic [NUM_PORTS-1:0]              port_mask
);
  logic [SIZE_W-1:0] q;
  logic [1:0]        r;
  logic [ADDR_W-1:0] acc;

  always_comb begin
    q         = tx_size >> 2;
    r         = tx_size[1:0];
    acc       = tx_addr;
    port_size = '0;
    port_addr = '0;
    port_mask = '0;
    for (int unsigned n = 0; n < NUM_PORTS; n++) begin
      port_size[n] = q + SIZE_W'(n < 32'(r));
      port_addr[n] = acc;
      port_mask[n] = |port_size[n];
      acc          = acc + ADDR_W'(port_size[n]) * ADDR_W'(BURST_BYTES);
    end
  end
endmodule

// File: rtl/axim_wr_controller.sv
// Write controller: splits one write request of tx_size bursts at tx_addr
// into up to four sub-requests for the HP write ports and pulses tx_done
// once every issued port has reported completion.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : request, status and per-port signals (master modport)
module axim_wr_controller
  import axim_wr_controller_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH   = 64,
  parameter int unsigned C_M_AXI_WR_BURST_LEN = 16,
  parameter int unsigned TX_SIZE_WIDTH        = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  axim_wr_controller_if.master  bus
);
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned SW = TX_SIZE_WIDTH;
  localparam int unsigned BURST_B = burst_bytes(C_M_AXI_DATA_WIDTH, C_M_AXI_WR_BURST_LEN);

  axim_state_t                      state;
  logic [SW-1:0]                    size_q;
  logic [AW-1:0]                    addr_q;
  logic [NUM_PORTS-1:0]             mask;
  logic [NUM_PORTS-1:0]             req_r;
  logic [NUM_PORTS-1:0][SW-1:0]     size_r;
  logic [NUM_PORTS-1:0][AW-1:0]     addr_r;
  logic                             tx_ready_r;
  logic                             tx_done_r;

  logic [NUM_PORTS-1:0]             done_v;
  logic [NUM_PORTS-1:0]             mask_left;
  logic [NUM_PORTS-1:0][SW-1:0]     split_size;
  logic [NUM_PORTS-1:0][AW-1:0]     split_addr;
  logic [NUM_PORTS-1:0]             split_mask;

  axim_wr_split #(
    .ADDR_W      (AW),
    .SIZE_W      (SW),
    .BURST_BYTES (BURST_B)
  ) u_split (
    .tx_size   (size_q),
    .tx_addr   (addr_q),
    .port_size (split_size),
    .port_addr (split_addr),
    .port_mask (split_mask)
  );

  assign done_v    = {bus.axim_hp3_tx_done, bus.axim_hp2_tx_done,
                      bus.axim_hp1_tx_done, bus.axim_hp0_tx_done};
  // Dones on ports that are not pending simply have no bit to clear.
  assign mask_left = mask & ~done_v;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      size_q     <= '0;
      addr_q     <= '0;
      mask       <= '0;
      req_r      <= '0;
      size_r     <= '0;
      addr_r     <= '0;
      tx_ready_r <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      req_r     <= '0;
      tx_done_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tx_ready_r && bus.tx_req) begin
            size_q     <= bus.tx_size;
            addr_q     <= bus.tx_addr;
            tx_ready_r <= 1'b0;
            state      <= ST_CALC;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        ST_CALC: begin
          mask  <= split_mask;
          state <= (split_mask == '0) ? ST_DONE : ST_ISSUE;
        end
        ST_ISSUE: begin
          req_r <= mask;
          for (int unsigned n = 0; n < NUM_PORTS; n++) begin
            size_r[n] <= split_size[n];
            addr_r[n] <= split_mask[n] ? split_addr[n] : '0;
          end
          mask  <= mask_left;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          mask <= mask_left;
          if (mask_left == '0) state <= ST_DONE;
        end
        ST_DONE: begin
          tx_done_r  <= 1'b1;
          tx_ready_r <= 1'b1;
          size_r     <= '0;
          addr_r     <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready         = tx_ready_r;
  assign bus.tx_done          = tx_done_r;
  assign bus.axim_hp0_tx_req  = req_r[0];
  assign bus.axim_hp1_tx_req  = req_r[1];
  assign bus.axim_hp2_tx_req  = req_r[2];
  assign bus.axim_hp3_tx_req  = req_r[3];
  assign bus.axim_hp0_tx_size = size_r[0];
  assign bus.axim_hp1_tx_size = size_r[1];
  assign bus.axim_hp2_tx_size = size_r[2];
  assign bus.axim_hp3_tx_size = size_r[3];
  assign bus.axim_hp0_tx_addr = addr_r[0];
  assign bus.axim_hp1_tx_addr = addr_r[1];
  assign bus.axim_hp2_tx_addr = addr_r[2];
  assign bus.axim_hp3_tx_addr = addr_r[3];
endmodule
